// File: rtl/w_residue_pkg.sv
// ---------------------------------------------------------------------------
// w_residue_pkg
//   Shared definitions for the residue RAM reader and writer logic:
//   the default address/digit/upper widths and the reader state encoding.
//   Contents:
//     RES_ADDR_W  : default RAM address width (matches computation_cycle)
//     RES_DIG_W   : default bits per stored plus/minus digit word
//     RES_UPPER_W : default width of the upper residue vectors
//     rd_state_e  : reader FSM state enum
// ---------------------------------------------------------------------------
package w_residue_pkg;

   localparam int RES_ADDR_W  = 7;
   localparam int RES_DIG_W   = 4;
   localparam int RES_UPPER_W = 6;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_FETCH   = 3'd1,
      ST_CAPTURE = 3'd2,
      ST_SEND    = 3'd3,
      ST_UPPER   = 3'd4,
      ST_DONE    = 3'd5
   } rd_state_e;

endpackage

// File: rtl/w_digit_sub.sv
// ---------------------------------------------------------------------------
// w_digit_sub
//   Borrow-in subtractor for one plus/minus digit group:
//   {0,a} - {0,b} - bin evaluated in W+1 bits. The extra top bit is the
//   borrow-out, which is also the sign of the group difference.
//   Ports:
//     i_a    in  W  plus operand
//     i_b    in  W  minus operand
//     i_bin  in  1  borrow in
//     o_diff out W  low W bits of the difference
//     o_bout out 1  borrow out (bit W of the difference)
// ---------------------------------------------------------------------------
module w_digit_sub
   import w_residue_pkg::*;
#(
   parameter int W = RES_DIG_W
) (
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   input  logic         i_bin,
   output logic [W-1:0] o_diff,
   output logic         o_bout
);

   logic [W:0] w_d;

   assign w_d    = {1'b0, i_a} - {1'b0, i_b} - {{W{1'b0}}, i_bin};
   assign o_diff = w_d[W-1:0];
   assign o_bout = w_d[W];

endmodule

// File: rtl/w_residue_reader.sv
// ---------------------------------------------------------------------------
// w_residue_reader
//   Reads the redundant residue w[j] (plus/minus digit pairs) back from the
//   residue RAM after a division, converts it to two's complement LS word
//   first, streams the nibbles over a valid/ready port, then folds in the
//   upper residue bits to produce the residue sign and the zero flag.
//
//   Build option: W_RESIDUE_READER_ZERO_EN
//     defined     -> zero accumulator present, res_zero reports exact zero
//     not defined -> zero accumulator removed, res_zero tied to 0
//
//   Ports:
//     clk, rst       clock (rising edge), asynchronous active-high reset
//     start          begin readout (only looked at in IDLE)
//     num_words      number of RAM words, addresses 0..num_words-1
//     w_upper_plus   upper residue, plus vector (held stable during a run)
//     w_upper_minus  upper residue, minus vector (held stable during a run)
//     rd_en/rd_addr  RAM read strobe and address
//     rd_data_plus   RAM plus half, one cycle after rd_en
//     rd_data_minus  RAM minus half, one cycle after rd_en
//     out_valid/out_ready/out_nibble/out_last  nibble stream
//     busy           high whenever not IDLE
//     done           one-cycle completion pulse
//     res_sign       residue negative (quotient needs correction)
//     res_zero       residue exactly zero
// ---------------------------------------------------------------------------
module w_residue_reader
   import w_residue_pkg::*;
#(
   parameter int ADDR_W  = RES_ADDR_W,
   parameter int DIG_W   = RES_DIG_W,
   parameter int UPPER_W = RES_UPPER_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ADDR_W-1:0]  num_words,
   input  logic [UPPER_W-1:0] w_upper_plus,
   input  logic [UPPER_W-1:0] w_upper_minus,
   output logic               rd_en,
   output logic [ADDR_W-1:0]  rd_addr,
   input  logic [DIG_W-1:0]   rd_data_plus,
   input  logic [DIG_W-1:0]   rd_data_minus,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DIG_W-1:0]   out_nibble,
   output logic               out_last,
   output logic               busy,
   output logic               done,
   output logic               res_sign,
   output logic               res_zero
);

   rd_state_e r_state, w_next;

   logic [ADDR_W-1:0]  r_addr;
   logic               r_borrow;
   logic [DIG_W-1:0]   r_nibble;
   logic               r_last;
   logic               r_res_sign;

   logic [DIG_W-1:0]   w_d_diff;
   logic               w_d_bout;
   logic [UPPER_W-1:0] w_u_diff;
   logic               w_u_bout;
   logic               w_is_last;

   // Last-word test is made before the increment, so addr never wraps even
   // when num_words is at the top of its range.
   assign w_is_last = (r_addr == (num_words - ADDR_W'(1)));

   w_digit_sub #(.W(DIG_W)) u_dig_sub (
      .i_a    (rd_data_plus),
      .i_b    (rd_data_minus),
      .i_bin  (r_borrow),
      .o_diff (w_d_diff),
      .o_bout (w_d_bout)
   );

   w_digit_sub #(.W(UPPER_W)) u_upper_sub (
      .i_a    (w_upper_plus),
      .i_b    (w_upper_minus),
      .i_bin  (r_borrow),
      .o_diff (w_u_diff),
      .o_bout (w_u_bout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_next = (num_words == '0) ? ST_UPPER : ST_FETCH;
            end
         end
         ST_FETCH:   w_next = ST_CAPTURE;
         ST_CAPTURE: w_next = ST_SEND;
         ST_SEND: begin
            if (out_ready) begin
               w_next = w_is_last ? ST_UPPER : ST_FETCH;
            end
         end
         ST_UPPER:   w_next = ST_DONE;
         ST_DONE:    w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr     <= '0;
         r_borrow   <= 1'b0;
         r_nibble   <= '0;
         r_last     <= 1'b0;
         r_res_sign <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_addr   <= '0;
                  r_borrow <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               r_nibble <= w_d_diff;
               r_borrow <= w_d_bout;
               r_last   <= w_is_last;
            end
            ST_SEND: begin
               if (out_ready && !w_is_last) begin
                  r_addr <= r_addr + ADDR_W'(1);
               end
            end
            ST_UPPER: begin
               // Borrow-out of the upper group is the top bit of u: the sign.
               r_res_sign <= w_u_bout;
            end
            default: ;
         endcase
      end
   end

`ifdef W_RESIDUE_READER_ZERO_EN
   logic r_zero_acc;
   logic r_res_zero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero_acc <= 1'b1;
         r_res_zero <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_zero_acc <= 1'b1;
               end
            end
            ST_CAPTURE: begin
               r_zero_acc <= r_zero_acc & (w_d_diff == '0);
            end
            ST_UPPER: begin
               // u == 0 needs both the low bits and the borrow-out clear.
               r_res_zero <= r_zero_acc & (w_u_diff == '0) & ~w_u_bout;
            end
            default: ;
         endcase
      end
   end

   assign res_zero = r_res_zero;
`else
   // Without the zero flag the upper difference bits have no consumer.
   logic w_unused;
   assign w_unused = ^w_u_diff;
   assign res_zero = 1'b0;
`endif

   assign rd_en      = (r_state == ST_FETCH);
   assign rd_addr    = r_addr;
   assign out_valid  = (r_state == ST_SEND);
   assign out_nibble = r_nibble;
   assign out_last   = r_last;
   assign busy       = (r_state != ST_IDLE);
   assign done       = (r_state == ST_DONE);
   assign res_sign   = r_res_sign;

endmodule

// File: tb/tb_w_residue_reader.sv
// ---------------------------------------------------------------------------
// tb_w_residue_reader
//   Directed-vector bench for w_residue_reader with a one-cycle-latency RAM
//   model and hand-computed expected nibbles, sign and zero flags.
// ---------------------------------------------------------------------------
module tb_w_residue_reader;

   localparam int ADDR_W  = 7;
   localparam int DIG_W   = 4;
   localparam int UPPER_W = 6;

`ifdef W_RESIDUE_READER_ZERO_EN
   localparam logic ZE = 1'b1;
`else
   localparam logic ZE = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               start;
   logic [ADDR_W-1:0]  num_words;
   logic [UPPER_W-1:0] w_upper_plus;
   logic [UPPER_W-1:0] w_upper_minus;
   logic               rd_en;
   logic [ADDR_W-1:0]  rd_addr;
   logic [DIG_W-1:0]   rd_data_plus;
   logic [DIG_W-1:0]   rd_data_minus;
   logic               out_valid;
   logic               out_ready;
   logic [DIG_W-1:0]   out_nibble;
   logic               out_last;
   logic               busy;
   logic               done;
   logic               res_sign;
   logic               res_zero;

   logic [DIG_W-1:0] mem_p [0:127];
   logic [DIG_W-1:0] mem_m [0:127];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int rd_cnt, vld_cnt, done_cnt, first_vld, lat;
   logic got_sign, got_zero;
   int addr_q[$];
   int nib_q[$];
   int last_q[$];

   w_residue_reader #(.ADDR_W(ADDR_W), .DIG_W(DIG_W), .UPPER_W(UPPER_W)) dut (
      .clk           (clk),
      .rst           (rst),
      .start         (start),
      .num_words     (num_words),
      .w_upper_plus  (w_upper_plus),
      .w_upper_minus (w_upper_minus),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data_plus  (rd_data_plus),
      .rd_data_minus (rd_data_minus),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_nibble    (out_nibble),
      .out_last      (out_last),
      .busy          (busy),
      .done          (done),
      .res_sign      (res_sign),
      .res_zero      (res_zero)
   );

   always #5 clk = ~clk;

   // Residue RAM: data appears one cycle after the read strobe.
   always @(posedge clk) begin
      if (rd_en) begin
         rd_data_plus  <= mem_p[rd_addr];
         rd_data_minus <= mem_m[rd_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_log();
      rd_cnt = 0; vld_cnt = 0; done_cnt = 0; first_vld = -1;
      addr_q.delete(); nib_q.delete(); last_q.delete();
   endtask

   // Log what the DUT shows now, then advance to 1 time unit after the next edge.
   task automatic step();
      if (rd_en) begin rd_cnt++; addr_q.push_back(int'(rd_addr)); end
      if (out_valid) begin
         vld_cnt++;
         if (first_vld < 0) first_vld = cyc;
      end
      if (out_valid && out_ready) begin
         nib_q.push_back(int'(out_nibble));
         last_q.push_back(int'(out_last));
      end
      if (done) done_cnt++;
      @(posedge clk); #1;
      cyc++;
   endtask

   task automatic wait_done(input int c0, input string tag);
      int b;
      b = 0;
      while (!done && b < 1000) begin step(); b++; end
      chk({tag, "_done_seen"}, done, 1);
      lat      = cyc - c0 + 1;
      got_sign = res_sign;
      got_zero = res_zero;
      step();
   endtask

   task automatic start_run(input int nw, input logic [UPPER_W-1:0] up,
                            input logic [UPPER_W-1:0] um, output int c0);
      num_words     = ADDR_W'(nw);
      w_upper_plus  = up;
      w_upper_minus = um;
      c0    = cyc;
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      int c0, b, bad, rc;
      logic [DIG_W-1:0] h_nib;
      logic h_last;

      for (int i = 0; i < 128; i++) begin mem_p[i] = '0; mem_m[i] = '0; end
      rst = 1'b1; start = 1'b0; num_words = '0; out_ready = 1'b1;
      w_upper_plus = '0; w_upper_minus = '0;
      rd_data_plus = '0; rd_data_minus = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outputs", {rd_en, rd_addr, out_valid, out_nibble, out_last,
                            busy, done, res_sign, res_zero}, 0);
      rst = 1'b0;
      step();
      clear_log();

      // 1: 3-5 -> E borrow; 0-0-1 -> F borrow; upper 0-0-1 negative
      mem_p[0] = 4'd3; mem_m[0] = 4'd5; mem_p[1] = 4'd0; mem_m[1] = 4'd0;
      start_run(2, 6'd0, 6'd0, c0);
      wait_done(c0, "t1");
      chk("t1_first_vld_cycle", first_vld - c0, 3);
      chk("t1_nib_count", nib_q.size(), 2);
      if (nib_q.size() == 2) begin
         chk("t1_nib0", nib_q[0], 4'hE);
         chk("t1_last0", last_q[0], 0);
         chk("t1_nib1", nib_q[1], 4'hF);
         chk("t1_last1", last_q[1], 1);
      end
      chk("t1_addr_seq", {addr_q.size(), addr_q[0], addr_q[1]}, {32'd2, 32'd0, 32'd1});
      chk("t1_sign", got_sign, 1);
      chk("t1_zero", got_zero, 0);
      chk("t1_done_count", done_cnt, 1);
      chk("t1_sign_held", res_sign, 1);

      // 2: exact zero
      clear_log();
      mem_p[0] = 4'd7; mem_m[0] = 4'd7;
      start_run(1, 6'd5, 6'd5, c0);
      wait_done(c0, "t2");
      chk("t2_nib_count", nib_q.size(), 1);
      if (nib_q.size() == 1) begin
         chk("t2_nib0", nib_q[0], 0);
         chk("t2_last0", last_q[0], 1);
      end
      chk("t2_sign", got_sign, 0);
      chk("t2_zero", got_zero, ZE);

      // 3: no words; upper 0-1 negative
      clear_log();
      start_run(0, 6'd0, 6'd1, c0);
      wait_done(c0, "t3");
      chk("t3_done_cycle", lat, 3);
      chk("t3_rd_count", rd_cnt, 0);
      chk("t3_vld_count", vld_cnt, 0);
      chk("t3_sign", got_sign, 1);
      chk("t3_zero", got_zero, 0);

      // 4: back-pressure; 9-2 -> 7, 1-4 -> D borrow, upper 2-1-1 -> 0
      clear_log();
      mem_p[0] = 4'd9; mem_m[0] = 4'd2; mem_p[1] = 4'd1; mem_m[1] = 4'd4;
      out_ready = 1'b0;
      start_run(2, 6'd2, 6'd1, c0);
      b = 0;
      while (!out_valid && b < 20) begin step(); b++; end
      chk("t4_valid_reached", out_valid, 1);
      h_nib = out_nibble; h_last = out_last; rc = rd_cnt;
      chk("t4_hold_nib", h_nib, 4'h7);
      bad = 0;
      repeat (5) begin
         step();
         if (!out_valid || out_nibble !== h_nib || out_last !== h_last || rd_en) bad++;
      end
      chk("t4_hold_stable", bad, 0);
      chk("t4_no_rd_while_stalled", rd_cnt, rc);
      out_ready = 1'b1;
      wait_done(c0, "t4");
      chk("t4_nibs", {nib_q.size(), nib_q[0], nib_q[1]}, {32'd2, 32'd7, 32'hD});
      chk("t4_sign", got_sign, 0);
      chk("t4_zero", got_zero, 0);

      // 5: reset during CAPTURE of word 3, then a fresh run from address 0
      clear_log();
      for (int i = 0; i < 8; i++) begin mem_p[i] = 4'(i + 4); mem_m[i] = 4'd1; end
      start_run(8, 6'd0, 6'd0, c0);
      b = 0;
      while (!(rd_en && rd_addr == 7'd3) && b < 100) begin step(); b++; end
      chk("t5_reach_addr3", rd_addr, 3);
      step();
      rst = 1'b1;
      step();
      chk("t5_outputs_after_rst", {rd_en, rd_addr, out_valid, out_nibble, out_last,
                                   busy, done, res_sign, res_zero}, 0);
      rc = rd_cnt;
      step();
      rst = 1'b0;
      step(); step();
      chk("t5_no_rd_after_rst", rd_cnt, rc);
      clear_log();
      mem_p[0] = 4'd4; mem_m[0] = 4'd1; mem_p[1] = 4'd2; mem_m[1] = 4'd2;
      start_run(2, 6'd0, 6'd0, c0);
      wait_done(c0, "t5");
      chk("t5_fresh_addr0", addr_q[0], 0);
      chk("t5_fresh_nibs", {nib_q.size(), nib_q[0], nib_q[1]}, {32'd2, 32'd3, 32'd0});

      // 6: start re-pulsed while busy
      clear_log();
      for (int i = 0; i < 3; i++) begin mem_p[i] = 4'd1; mem_m[i] = 4'd0; end
      start_run(3, 6'd3, 6'd1, c0);
      step();
      start = 1'b1; step(); start = 1'b0;
      step(); step();
      start = 1'b1; step(); start = 1'b0;
      wait_done(c0, "t6");
      repeat (4) step();
      chk("t6_addr_seq", {addr_q.size(), addr_q[0], addr_q[1], addr_q[2]},
          {32'd3, 32'd0, 32'd1, 32'd2});
      chk("t6_done_count", done_cnt, 1);
      chk("t6_nib_count", nib_q.size(), 3);
      chk("t6_sign", got_sign, 0);

      // 7: largest word count, all-zero residue
      clear_log();
      for (int i = 0; i < 128; i++) begin mem_p[i] = 4'd0; mem_m[i] = 4'd0; end
      start_run(127, 6'd0, 6'd0, c0);
      wait_done(c0, "t7");
      chk("t7_rd_count", addr_q.size(), 127);
      chk("t7_last_addr", addr_q[addr_q.size() - 1], 126);
      bad = 0;
      foreach (last_q[i]) if (last_q[i] != ((i == 126) ? 1 : 0)) bad++;
      chk("t7_last_flags", bad, 0);
      chk("t7_nib_count", nib_q.size(), 127);
      chk("t7_sign", got_sign, 0);
      chk("t7_zero", got_zero, ZE);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
